// File: rtl/chess_sprite_ctrl_if.sv
// Board-update handshake between game logic (master) and the sprite
// controller (slave). wr_req is a level held until wr_ack pulses.
interface chess_sprite_ctrl_if;
  logic       wr_req;
  logic [5:0] wr_square;   // {row[2:0], col[2:0]}, row 0 top, col 0 left
  logic [3:0] wr_piece;
  logic       wr_ack;

  modport master (output wr_req, output wr_square, output wr_piece, input wr_ack);
  modport slave  (input wr_req, input wr_square, input wr_piece, output wr_ack);
endinterface

// File: rtl/chess_sprite_ctrl.sv
// chess_sprite_ctrl: maps VGA pixels to board squares, looks up the piece in
// an internal 8x8 board store and issues sprite ROM address / flags through a
// fixed pipeline (inputs registered, square decode, board read + outputs).
// Board updates are accepted only while the registered DrawY is in vertical
// blanking, so a displayed frame never tears.
// Optional feature macro: BOARD_FLIP_EN (adds the flip port; orientation is
// latched once per frame at the start of vertical blanking).
module chess_sprite_ctrl #(
  parameter int SPRITE_DIM = 60,
  parameter int BOARD_X0   = 80,
  parameter int BOARD_Y0   = 0,
  parameter int V_ACTIVE   = 480
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
`ifdef BOARD_FLIP_EN
  input  logic        flip,
`endif
  chess_sprite_ctrl_if.slave wr,
  output logic [15:0] rom_address,
  output logic [3:0]  piece_id,
  output logic        in_board,
  output logic        square_light,
  output logic        pix_valid
);

  localparam int         BOARD_W = 8 * SPRITE_DIM;
  localparam logic [9:0] X_LO    = 10'(BOARD_X0);
  localparam logic [9:0] X_HI    = 10'(BOARD_X0 + BOARD_W);
  localparam logic [9:0] Y_LO    = 10'(BOARD_Y0);
  localparam logic [9:0] Y_HI    = 10'(BOARD_Y0 + BOARD_W);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);

  // Constant multiply as a sum of shifted copies of x, one per set bit of k.
  function automatic logic [15:0] mul_const(input logic [15:0] x, input logic [15:0] k);
    logic [15:0] acc;
    acc = '0;
    for (int b = 0; b < 16; b++)
      if (k[b]) acc = acc + (x << b);
    return acc;
  endfunction

  // Standard chess start position, indexed by {row, col}.
  function automatic logic [3:0] start_piece(input logic [5:0] sq);
    logic [3:0] back;
    case (sq[2:0])
      3'd0, 3'd7: back = 4'd10;
      3'd1, 3'd6: back = 4'd8;
      3'd2, 3'd5: back = 4'd9;
      3'd3:       back = 4'd11;
      default:    back = 4'd12;
    endcase
    case (sq[5:3])
      3'd0:    return back;
      3'd1:    return 4'd7;
      3'd6:    return 4'd1;
      3'd7:    return back - 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_ACK} wr_state_t;

  wr_state_t  wr_state;
  logic [3:0] board [64];

  logic [9:0] x_p0, y_p0;
  logic       vld_p0;
  logic [2:0] col_p1, row_p1;
  logic [5:0] lx_p1, ly_p1;
  logic       inb_p1, vld_p1;

  // ---- stage 0: register pixel coordinate and blank ----
  // y_p0 is reset because it gates the write scheduler.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      y_p0   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      y_p0   <= DrawY;
      vld_p0 <= blank;
    end
  end

  // X coordinate is pure data and needs no reset.
  always_ff @(posedge vga_clk) begin
    x_p0 <= DrawX;
  end

  // ---- stage 1: square decode by comparator chain, local offsets ----
  logic [9:0]  rx, ry;
  logic [2:0]  col_s1, row_s1;
  logic [15:0] lx_full, ly_full;
  logic        inb_s1;

  // Column/row are the count of square boundaries the offset has passed.
  always_comb begin
    rx     = x_p0 - X_LO;
    ry     = y_p0 - Y_LO;
    col_s1 = '0;
    row_s1 = '0;
    for (int k = 1; k < 8; k++) begin
      if (rx >= 10'(k * SPRITE_DIM)) col_s1 = 3'(k);
      if (ry >= 10'(k * SPRITE_DIM)) row_s1 = 3'(k);
    end
    lx_full = 16'(rx) - mul_const(16'(col_s1), 16'(SPRITE_DIM));
    ly_full = 16'(ry) - mul_const(16'(row_s1), 16'(SPRITE_DIM));
    inb_s1  = (x_p0 >= X_LO) && (x_p0 < X_HI) && (y_p0 >= Y_LO) && (y_p0 < Y_HI);
  end

  // Stage 1 flags carry reset; decoded square data does not.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      inb_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      inb_p1 <= inb_s1;
      vld_p1 <= vld_p0;
    end
  end

  // Stage 1 data registers.
  always_ff @(posedge vga_clk) begin
    col_p1 <= col_s1;
    row_p1 <= row_s1;
    lx_p1  <= lx_full[5:0];
    ly_p1  <= ly_full[5:0];
  end

  // ---- stage 2: board read and output registers ----
  logic [5:0] rd_sq;
  logic [3:0] piece_rd;
  logic       piece_ok;

`ifdef BOARD_FLIP_EN
  logic flip_q, flip_done;

  // Latch orientation once, on the first blanking line of each frame.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      flip_q    <= 1'b0;
      flip_done <= 1'b0;
    end else if (y_p0 == V_ACT) begin
      if (!flip_done) flip_q <= flip;
      flip_done <= 1'b1;
    end else begin
      flip_done <= 1'b0;
    end
  end

  // 7-row / 7-col on 3 bits is bitwise inversion.
  assign rd_sq = flip_q ? {~row_p1, ~col_p1} : {row_p1, col_p1};
`else
  assign rd_sq = {row_p1, col_p1};
`endif

  assign piece_rd = board[rd_sq];
  assign piece_ok = inb_p1 && (piece_rd >= 4'd1) && (piece_rd <= 4'd12);

  // Output register: ROM address and flags, all zero off-board.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address  <= '0;
      piece_id     <= '0;
      in_board     <= 1'b0;
      square_light <= 1'b0;
      pix_valid    <= 1'b0;
    end else begin
      rom_address  <= piece_ok ? (mul_const(16'(piece_rd - 4'd1), 16'(SPRITE_DIM * SPRITE_DIM))
                                  + mul_const(16'(ly_p1), 16'(SPRITE_DIM)) + 16'(lx_p1))
                               : 16'd0;
      piece_id     <= piece_ok ? piece_rd : 4'd0;
      in_board     <= inb_p1;
      square_light <= inb_p1 & ~(row_p1[0] ^ col_p1[0]);
      pix_valid    <= vld_p1;
    end
  end

  // Write scheduler and board store: one write per accept, only in blanking.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      wr_state  <= S_IDLE;
      wr.wr_ack <= 1'b0;
      for (int i = 0; i < 64; i++) board[i] <= start_piece(6'(i));
    end else begin
      case (wr_state)
        S_IDLE: begin
          if (wr.wr_req && (y_p0 >= V_ACT) && !wr.wr_ack) begin
            board[wr.wr_square] <= wr.wr_piece;
            wr.wr_ack           <= 1'b1;
            wr_state            <= S_ACK;
          end
        end
        default: begin
          wr.wr_ack <= 1'b0;
          wr_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/chess_sprite_ctrl.md
# chess_sprite_ctrl

Scheduler and address generator for the shared piece-sprite ROM. It maps each VGA pixel (DrawX/DrawY) to a board square, looks the square up in an internal 8x8 board-state store, and issues the sprite ROM address, palette select and board flags through a fixed 2-cycle pipeline. It also owns the board store's single write port and accepts game-logic updates only during vertical blanking, so a frame never tears. It sits between the VGA timing controller and the sprite ROM/palette/colour mapper.

## Interface
- SPRITE_DIM, 60: sprite and square edge in pixels; sprites are stored row-major, SPRITE_DIM² words each.
- BOARD_X0, 80: first board column in DrawX; the board spans BOARD_X0 .. BOARD_X0+8*SPRITE_DIM-1.
- BOARD_Y0, 0: first board row in DrawY.
- V_ACTIVE, 480: first DrawY value of vertical blanking.

Ports:
- vga_clk  in  1  pixel clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- blank  in  1  1 = active video.
- wr_req  in  1  board update request, level, held until acked.
- wr_square  in  6  {row[2:0], col[2:0]}, where row 0 is the top and col 0 is the left.
- wr_piece  in  4  piece code: 0 empty; 1–6 white P,N,B,R,Q,K; 7–12 black P,N,B,R,Q,K; 13–15 treated as empty.
- wr_ack  out  1  single-cycle acceptance pulse.
- rom_address  out  16  sprite ROM word address.
- piece_id  out  4  piece code of the current pixel's square; 0 outside the board.
- in_board  out  1  pixel lies inside the 480×480 board.
- square_light  out  1  1 when (row+col) is even.
- pix_valid  out  1  delayed blank, aligned with the other outputs.
- (BOARD_FLIP_EN only) flip  in  1  requested board orientation.

## Operation
- Stage 0 registers DrawX, DrawY and blank.
- Stage 1 computes:
  - col/row by comparator chain against multiples of SPRITE_DIM; no dividers.
  - local offsets lx, ly in the range 0..59.
  - in_board.
- Stage 2 reads board[row][col] and registers all outputs:
  - rom_address = (piece−1)*3600 + ly*60 + lx for piece 1–12; 0 otherwise.
  - Multiplies by constants use shift-add. The maximum address is 43199, which fits in 16 bits.
- Outside the board: piece_id=0, in_board=0, square_light=0, rom_address=0.
- Board store: 64 × 4-bit registers. Reset loads the standard start position:
  - row 0: black R,N,B,Q,K,B,N,R (10,8,9,11,12,9,8,10)
  - row 1: black pawns (7)
  - rows 2–5: 0
  - row 6: white pawns (1)
  - row 7: white R,N,B,Q,K,B,N,R (4,2,3,5,6,3,2,4)
- Write scheduler states:
  - IDLE: accept when wr_req=1, the stage-0 registered DrawY ≥ V_ACTIVE, and wr_ack=0. The write occurs on that edge; go to ACK.
  - ACK: wr_ack=1 for exactly this cycle; return to IDLE.
  - Writes are therefore at most one per 2 cycles.
- wr_req during active lines waits, with no ack, until the next blanking interval.
- Reads and writes never overlap in time, so there is no bypass path.

## Timing
- Latency: outputs correspond to the DrawX/DrawY/blank sampled 2 posedges earlier. The ROM samples rom_address on the following negedge.
- All outputs reset to 0. The board resets to the start position. The scheduler resets to IDLE.
- Reset asserted mid-ACK drops wr_ack immediately. An in-flight write that has already occurred is overwritten by the reset contents.
- wr_req deasserted before ack: no write occurs.
- wr_req held after ack: a new write may be accepted 2 cycles after the previous acceptance, and the same data is rewritten. Requesters must drop or change wr_req on seeing wr_ack.
- DrawY wrap from 524 to 0 ends the update window. An acceptance on the last blanking cycle is still honoured.

## Configuration
- BOARD_FLIP_EN defined:
  - The flip port exists. flip is sampled into flip_q only on the first cycle with registered DrawY = V_ACTIVE (frame boundary), so orientation never changes mid-frame.
  - When flip_q=1, the board read uses row'=7−row and col'=7−col. lx/ly and square_light are unchanged, since the checker pattern is symmetric.
  - flip_q resets to 0.
- BOARD_FLIP_EN undefined: no flip port; fixed orientation.

## Test plan
- Reset, then pixel (80,0) with blank=1: 2 cycles later in_board=1, piece_id=10, rom_address=9*3600=32400, square_light=1.
- Pixel (80+4*60+7, 7*60+3): 2 cycles later piece_id=6, rom_address=5*3600+3*60+7=18187, square_light=0.
- Pixel (79,100) and pixel (560,100): in_board=0, piece_id=0, rom_address=0.
- wr_req with square 36 (row 4, col 4) and piece 1, raised at DrawY=100: no ack until DrawY=480; then a single wr_ack pulse. The next frame reads piece_id=1 at (350,250).
- wr_req held for 10 blanking cycles: wr_ack pulses every 2nd cycle. Reset asserted during a pulse drops wr_ack immediately and restores square 36 to 0.
- With BOARD_FLIP_EN, flip=1 raised mid-frame: the current frame is unchanged. From the next frame, (80,0) shows piece_id=4.
